// File: rtl/fpu_issue_ctrl.sv
// Two-requester issue controller for a fixed-latency FPU pipeline.
// Round-robin arbitration, in-flight tag tracking, and flush/drain sequencing.
//
// state | meaning
// RUN   | issuing allowed while below the outstanding limit
// DRAIN | issue blocked; waiting for every in-flight op to return
module fpu_issue_ctrl #(
    parameter int LATENCY = 4,
    parameter int MAX_OUT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [1:0]  req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [1:0]  req1_op,
    output logic        fpu_valid,
    output logic [31:0] fpu_a,
    output logic [31:0] fpu_b,
    output logic [1:0]  fpu_op,
    input  logic [31:0] fpu_result,
    output logic        rsp0_valid,
    output logic        rsp1_valid,
    output logic [31:0] rsp_data,
    input  logic        flush,
    output logic        flush_done,
    output logic [2:0]  outstanding
);

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_t;

    localparam logic [2:0] MAX_OUT_L = 3'(MAX_OUT);

    state_t             state;
    logic               ptr;
    logic               grant;
    logic               can_issue;
    logic               accept;
    logic               fpu_id;
    logic [LATENCY-1:0] tag_v;
    logic [LATENCY-1:0] tag_id;
    logic [LATENCY:0]   all_v;
    logic [LATENCY:0]   all_id;
    logic               tail_v;
    logic               tail_id;
    logic               retire_next;

    // Stage 0 of the tag chain is the issue register itself; the tail lines up
    // with fpu_result exactly LATENCY cycles after fpu_valid.
    assign all_v       = {tag_v, fpu_valid};
    assign all_id      = {tag_id, fpu_id};
    assign tail_v      = all_v[LATENCY];
    assign tail_id     = all_id[LATENCY];
    assign retire_next = all_v[LATENCY-1];

    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ptr;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    assign can_issue  = (state == RUN) && !flush && (outstanding < MAX_OUT_L) && !rst;
    assign req0_ready = can_issue && req0_valid && !grant;
    assign req1_ready = can_issue && req1_valid && grant;
    assign accept     = req0_ready || req1_ready;

    assign rsp0_valid = tail_v && !tail_id;
    assign rsp1_valid = tail_v && tail_id;
    assign rsp_data   = fpu_result;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            ptr         <= 1'b0;
            outstanding <= 3'd0;
            fpu_valid   <= 1'b0;
            fpu_id      <= 1'b0;
            fpu_a       <= 32'd0;
            fpu_b       <= 32'd0;
            fpu_op      <= 2'd0;
            tag_v       <= '0;
            tag_id      <= '0;
            flush_done  <= 1'b0;
        end else begin
            fpu_valid  <= accept;
            tag_v      <= all_v[LATENCY-1:0];
            tag_id     <= all_id[LATENCY-1:0];
            flush_done <= 1'b0;

            if (accept) begin
                fpu_id <= grant;
                ptr    <= !grant;
                if (grant) begin
                    fpu_a  <= req1_a;
                    fpu_b  <= req1_b;
                    fpu_op <= req1_op;
                end else begin
                    fpu_a  <= req0_a;
                    fpu_b  <= req0_b;
                    fpu_op <= req0_op;
                end
            end

            // Count drops as an op reaches the tail, so it reads 0 in the response cycle.
            if (accept && !retire_next && outstanding != 3'd7) begin
                outstanding <= outstanding + 3'd1;
            end else if (!accept && retire_next && outstanding != 3'd0) begin
                outstanding <= outstanding - 3'd1;
            end

            case (state)
                RUN: begin
                    if (flush) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (outstanding == 3'd0) begin
                        state      <= RUN;
                        flush_done <= 1'b1;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: doc/fpu_issue_ctrl.md
FPU_ISSUE_CTRL -- requirements
Module: fpu_issue_ctrl

Interface
REQ-001 SHALL have parameter LATENCY, default 4: cycles from fpu_valid high to matching fpu_result (legal 1..8).
REQ-002 SHALL have parameter MAX_OUT, default 4: maximum accepted-but-unretired operations (legal 1..7).
REQ-003 SHALL have one clock and a synchronous, active-high reset.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 reqN_valid  in  1  requester N (N=0,1) presents an operation.
REQ-007 reqN_ready  out  1  operation from requester N accepted this cycle if valid.
REQ-008 reqN_a, reqN_b  in  32  IEEE-754 single operands.
REQ-009 reqN_op  in  2  operator code (00 add, 01 sub, others passed through).
REQ-010 fpu_valid  out  1  registered issue strobe to the FPU pipeline.
REQ-011 fpu_a, fpu_b  out  32  registered operands.
REQ-012 fpu_op  out  2  registered operator.
REQ-013 fpu_result  in  32  FPU result, valid exactly LATENCY cycles after issue.
REQ-014 rspN_valid  out  1  fpu_result belongs to requester N this cycle.
REQ-015 rsp_data  out  32  equals fpu_result (shared by both requesters).
REQ-016 flush  in  1  request to stop issue and drain the pipeline.
REQ-017 flush_done  out  1  one-cycle registered pulse when drain completes.
REQ-018 outstanding  out  3  current count of unretired operations.

Function
REQ-019 SHALL implement states RUN and DRAIN; reset state RUN.
REQ-020 SHALL define can_issue = (state==RUN) && !flush && (outstanding<MAX_OUT).
REQ-021 SHALL grant round-robin: only one valid -> that one; both valid -> requester at pointer; pointer reset 0, set to other requester after each accept.
REQ-022 SHALL assert reqN_ready = can_issue && grant==N; ready may depend combinationally on valid; at most one ready per cycle.
REQ-023 SHALL never assert ready to a requester whose valid is low.
REQ-024 On accept at edge E: fpu_valid=1 and fpu_a/b/op = granted inputs during the cycle after E; otherwise fpu_valid=0, data held.
REQ-025 SHALL keep a LATENCY-deep tag shift register {valid,id}, loaded in step with fpu_valid.
REQ-026 SHALL drive rspN_valid = tail.valid && tail.id==N, combinationally, in the cycle fpu_result is valid.
REQ-027 outstanding SHALL +1 on accept, -1 on tail retire, unchanged on both same cycle; never wraps.
REQ-028 RUN -> DRAIN on flush=1 (no accept that cycle); flush in DRAIN ignored.
REQ-029 DRAIN -> RUN when outstanding==0; flush_done=1 the cycle after that transition edge, else 0.
REQ-030 Flush with outstanding==0 SHALL spend exactly one cycle in DRAIN.
REQ-031 SHALL not reorder responses; they retire in issue order.

Reset
REQ-032 rst SHALL clear: state=RUN, pointer=0, outstanding=0, fpu_valid=0, fpu_a/b/op=0, all tag valids=0, flush_done=0.
REQ-033 Reset mid-operation SHALL discard in-flight tags; no rspN_valid until new issues retire.
REQ-034 rst SHALL take priority over flush and accept in the same cycle.

Verification
REQ-035 req0 only, a=3F800000 b=40000000 op=00 at cycle 1 -> fpu_valid cycle 2 with same values; rsp0_valid cycle 6; outstanding 1 during cycles 2-5, 0 at cycle 6.
REQ-036 both valid continuously for 8 cycles -> grants alternate 0,1,0,1; ready drops after 4 accepts until the first retire; rsp order matches grant order.
REQ-037 flush while outstanding=3 -> no ready until return to RUN; flush_done one pulse the cycle after outstanding reaches 0.
REQ-038 flush with outstanding=0 -> one DRAIN cycle, then flush_done=1 for one cycle, then RUN.
REQ-039 rst asserted with 2 ops in flight -> outputs at reset values next cycle; no rspN_valid afterwards.
REQ-040 accept and retire in same cycle at outstanding=MAX_OUT-1 -> outstanding unchanged, ready stays high.
